// File: rtl/key_pkg.sv
// Shared types and constants for the multi-key scan controller and its event queue.
package key_pkg;

    // 10 ms of stable level at 100 MHz
    localparam int unsigned DEBOUNCE_CYC_100M = 1000000;

    // Widest key index supported (NUM_KEYS up to 8)
    localparam int KEY_IDX_W = 3;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] COMMIT   = 2'd2;

    typedef enum logic [1:0] {
        ST_SCAN     = SCAN,
        ST_DEBOUNCE = DEBOUNCE,
        ST_COMMIT   = COMMIT
    } scan_state_e;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] key;
        logic                 press;
    } key_evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous event FIFO with registered head; push and pop may occur together,
// including when full.
module key_evt_fifo
    import key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  key_evt_t push_data,
    input  logic     ready,
    output logic     valid,
    output key_evt_t head,
    output logic     full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    key_evt_t      mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic          pop;
    logic          do_push;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count_after_pop;

    assign full            = (count == (PW+1)'(DEPTH));
    assign pop             = valid && ready;
    assign do_push         = push && (!full || pop);
    assign rd_next         = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign count_after_pop = count - (PW+1)'(pop);

    // NOTE: storage carries no reset; occupancy is tracked by count, so stale
    // entries are never presented and resetting the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count_after_pop + (PW+1)'(do_push);
            valid <= (count_after_pop != '0) || do_push;
            // Head comes from storage unless the queue drains and the new push becomes head
            if (count_after_pop == '0) begin
                if (do_push) begin
                    head <= push_data;
                end
            end else begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// Round-robin multi-key debouncer sharing one timer, with a queued event output.
// Define KEY_SCAN_RELEASE_EN to queue release edges as well as presses.
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_100M,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk_100M,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         key_in,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_KEYS)-1:0] evt_key,
    output logic                        evt_press,
    output logic [NUM_KEYS-1:0]         key_state,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam int TMR_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync;
    logic [NUM_KEYS-1:0] stable;
    logic [1:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    idx;
    logic [TMR_W-1:0]    timer;

    logic                found;
    logic [IDX_W-1:0]    found_idx;
    logic                want_push;
    logic                can_commit;
    logic                push;
    logic                pop;
    logic                fifo_full;
    key_evt_t            push_evt;
    key_evt_t            head;
    logic                head_unused;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= unsigned'(NUM_KEYS)) begin
            sum = sum - unsigned'(NUM_KEYS);
        end
        return IDX_W'(sum);
    endfunction

    // NOTE: every always_comb output gets a default before any branch so no latch
    // is inferred; combinational code uses blocking '=', clocked code uses '<='.
    always_comb begin
        found     = 1'b0;
        found_idx = ptr;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (!found && (sync[rr_idx(ptr, k)] != stable[rr_idx(ptr, k)])) begin
                found     = 1'b1;
                found_idx = rr_idx(ptr, k);
            end
        end
    end

`ifdef KEY_SCAN_RELEASE_EN
    assign want_push = 1'b1;
`else
    // Releases only update key_state, so they never wait on the queue
    assign want_push = ~stable[idx];
`endif

    assign pop            = evt_valid && evt_ready;
    assign can_commit     = !want_push || !fifo_full || pop;
    assign push           = (state == COMMIT) && want_push && can_commit;
    assign push_evt.key   = KEY_IDX_W'(idx);
    assign push_evt.press = ~stable[idx];

    always_ff @(posedge clk_100M) begin
        if (!rst) begin
            sync_meta <= '0;
            sync      <= '0;
            stable    <= '0;
            state     <= SCAN;
            ptr       <= '0;
            idx       <= '0;
            timer     <= '0;
        end else begin
            sync_meta <= key_in;
            sync      <= sync_meta;
            case (state)
                SCAN: begin
                    if (found) begin
                        idx   <= found_idx;
                        timer <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (sync[idx] == stable[idx]) begin
                        ptr   <= rr_idx(idx, 1);
                        state <= SCAN;
                    end else if (timer == TMR_W'(DEBOUNCE_CYC - 1)) begin
                        state <= COMMIT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COMMIT: begin
                    if (can_commit) begin
                        stable[idx] <= ~stable[idx];
                        ptr         <= rr_idx(idx, 1);
                        state       <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_100M),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_evt),
        .ready     (evt_ready),
        .valid     (evt_valid),
        .head      (head),
        .full      (fifo_full)
    );

    assign evt_key     = head.key[IDX_W-1:0];
`ifdef KEY_SCAN_RELEASE_EN
    assign evt_press   = head.press;
`else
    assign evt_press   = 1'b1;
`endif
    // Upper index bits and, without release events, the press bit go unread
    assign head_unused = ^{head.key, head.press};

    assign key_state = stable;
    assign busy      = (state == DEBOUNCE) || (state == COMMIT);

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl: reset, latency table, bounce, ordering,
// back-pressure stall and reset during debounce.
module tb_key_scan_ctrl;

    localparam int NK = 4;
    localparam int D  = 16;
    localparam int FD = 4;

`ifdef KEY_SCAN_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic          clk_100M = 1'b0;
    logic          rst      = 1'b0;
    logic [NK-1:0] key_in   = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_key;
    logic          evt_press;
    logic [NK-1:0] key_state;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int key;
        bit press;
        int at;
    } got_t;
    got_t got_q[$];

    typedef struct {
        logic [NK-1:0] keys;
        int            exp_key;
        bit            exp_press;
        logic [NK-1:0] exp_state;
    } vec_t;
    vec_t vecs[6];

    key_scan_ctrl #(
        .NUM_KEYS     (NK),
        .DEBOUNCE_CYC (D),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .key_in    (key_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_press (evt_press),
        .key_state (key_state),
        .busy      (busy)
    );

    always #5 clk_100M = ~clk_100M;

    always @(posedge clk_100M) cyc <= cyc + 1;

    always @(negedge clk_100M) begin
        if (rst && evt_valid && evt_ready) begin
            got_q.push_back('{int'(evt_key), evt_press, cyc});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int n;
        bit exp_evt;
        int exp_keys[5];
        bit exp_press[5];

        vecs[0] = '{4'b0010, 1, 1'b1, 4'b0010};
        vecs[1] = '{4'b0000, 1, 1'b0, 4'b0000};
        vecs[2] = '{4'b1000, 3, 1'b1, 4'b1000};
        vecs[3] = '{4'b1001, 0, 1'b1, 4'b1001};
        vecs[4] = '{4'b0001, 3, 1'b0, 4'b0001};
        vecs[5] = '{4'b0000, 0, 1'b0, 4'b0000};

        // Reset held for 7 edges
        rst       = 1'b0;
        evt_ready = 1'b1;
        ticks(7);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_state", int'(key_state), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        ticks(3);
        check("idle_busy", int'(busy), 0);

        // Single-key edges: latency, state, head contents
        for (int v = 0; v < 6; v++) begin
            key_in = vecs[v].keys;
            n = 0;
            do begin
                tick();
                n++;
            end while (key_state != vecs[v].exp_state && n < 200);
            check($sformatf("v%0d_latency", v), n, D + 4);
            check($sformatf("v%0d_state", v), int'(key_state), int'(vecs[v].exp_state));
            exp_evt = vecs[v].exp_press || REL_EN;
            check($sformatf("v%0d_valid", v), int'(evt_valid), int'(exp_evt));
            if (exp_evt) begin
                check($sformatf("v%0d_key", v), int'(evt_key), vecs[v].exp_key);
                check($sformatf("v%0d_press", v), int'(evt_press), int'(vecs[v].exp_press));
            end
            ticks(2);
            check($sformatf("v%0d_count", v), got_q.size(), int'(exp_evt));
            got_q.delete();
        end

        // Bounce on key 2: 1 cycle high, 1.5 cycles low, for 200 ns
        repeat (8) begin
            key_in[2] = 1'b1;
            #10;
            key_in[2] = 1'b0;
            #15;
        end
        check("bounce_no_evt", got_q.size(), 0);
        check("bounce_state", int'(key_state), 0);
        key_in[2] = 1'b1;
        ticks(60);
        check("bounce_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            check("bounce_key", got_q[0].key, 2);
            check("bounce_press", int'(got_q[0].press), 1);
        end
        check("bounce_final_state", int'(key_state), 4'b0100);
        key_in = '0;
        ticks(60);
        got_q.delete();

        // Reset to put the round-robin pointer back at 0, then keys 0 and 3 together
        rst = 1'b0;
        ticks(3);
        rst = 1'b1;
        check("rr_rst_state", int'(key_state), 0);
        key_in = 4'b1001;
        ticks(60);
        check("rr_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("rr_first_key", got_q[0].key, 0);
            check("rr_second_key", got_q[1].key, 3);
            check("rr_gap", got_q[1].at - got_q[0].at, D + 2);
        end
        key_in = '0;
        ticks(60);
        got_q.delete();

        // Back-pressure: four presses fill the queue, the fifth pushing edge stalls
        evt_ready = 1'b0;
        for (int k = 0; k < NK; k++) begin
            key_in[k] = 1'b1;
            ticks(30);
        end
        key_in[0] = 1'b0;
        ticks(30);
        if (!REL_EN) begin
            key_in[0] = 1'b1;
            ticks(30);
        end
        check("stall_busy", int'(busy), 1);
        check("stall_valid", int'(evt_valid), 1);
        check("stall_state", int'(key_state), REL_EN ? 4'b1111 : 4'b1110);
        check("stall_no_pop", got_q.size(), 0);
        check("stall_head_key", int'(evt_key), 0);
        check("stall_head_press", int'(evt_press), 1);
        evt_ready = 1'b1;
        ticks(20);
        exp_keys  = '{0, 1, 2, 3, 0};
        exp_press = '{1'b1, 1'b1, 1'b1, 1'b1, !REL_EN};
        check("drain_count", got_q.size(), 5);
        if (got_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("drain%0d_key", i), got_q[i].key, exp_keys[i]);
                check($sformatf("drain%0d_press", i), int'(got_q[i].press), int'(exp_press[i]));
            end
        end
        check("drain_busy", int'(busy), 0);
        check("drain_state", int'(key_state), REL_EN ? 4'b1110 : 4'b1111);

        // Reset while key 1 is being debounced
        key_in = '0;
        ticks(60);
        got_q.delete();
        key_in[1] = 1'b1;
        ticks(8);
        check("mid_db_busy", int'(busy), 1);
        rst = 1'b0;
        ticks(3);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_state", int'(key_state), 0);
        check("mid_rst_valid", int'(evt_valid), 0);
        rst = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!evt_valid && n < 200);
        check("redetect_latency", n, D + 4);
        check("redetect_key", int'(evt_key), 1);
        check("redetect_press", int'(evt_press), 1);
        check("redetect_state", int'(key_state), 4'b0010);
        ticks(2);
        check("redetect_count", got_q.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_scan_ctrl.md
Name: key_scan_ctrl

Overview:
- Multi-key front-end controller: a scheduler time-shares one debounce timer across NUM_KEYS raw push-buttons using round-robin arbitration.
- Confirmed press/release edges are queued as events in a small FIFO with a valid/ready output.
- Sits between the board buttons and downstream LED/mode logic; supersedes the single-key detector in multi-button designs.

Parameters:
- NUM_KEYS, 4, number of raw key inputs (2..8)
- DEBOUNCE_CYC, 1000000, consecutive stable cycles needed to accept an edge (10 ms at 100 MHz)
- FIFO_DEPTH, 4, event queue depth (power of 2)

Ports:
- clk_100M  input  1  system clock, 100 MHz
- rst  input  1  reset; synchronous, active-low
- key_in  input  NUM_KEYS  raw asynchronous key levels, 1 = pressed
- evt_valid  output  1  event available at FIFO head
- evt_ready  input  1  consumer accepts the head event
- evt_key  output  $clog2(NUM_KEYS)  index of the key for the head event
- evt_press  output  1  1 = press edge, 0 = release edge
- key_state  output  NUM_KEYS  debounced stable level per key
- busy  output  1  debounce timer currently owned by a key

Behaviour:
- Reset (rst==0 sampled on a clk_100M edge) clears the following to 0:
  - sync flops, stable (so key_state=0), rr pointer, timer, FIFO pointers and count
  - evt_valid, evt_key, evt_press, busy
  - FSM state = SCAN
- Each key passes through a 2-flop synchronizer (sync). The remaining logic uses sync only.
- FSM states: SCAN, DEBOUNCE, COMMIT.
- SCAN:
  - Search keys ptr, ptr+1, ... (modulo NUM_KEYS) for the first i with sync[i]!=stable[i].
  - If found: latch idx=i, timer=0, go to DEBOUNCE. If none: stay in SCAN.
- DEBOUNCE:
  - busy=1.
  - If sync[idx]==stable[idx] (glitch), abort: ptr=idx+1 mod NUM_KEYS, go to SCAN, no event.
  - Else if timer==DEBOUNCE_CYC-1: go to COMMIT.
  - Else timer++. The timer width is $clog2(DEBOUNCE_CYC).
- COMMIT:
  - busy=1.
  - If FIFO not full, or a pop occurs this cycle: push {idx, ~stable[idx]}, toggle stable[idx], ptr=idx+1 mod NUM_KEYS, go to SCAN.
  - Otherwise stall in COMMIT. stable is unchanged and no event is dropped.
- Other keys are not tracked while the timer is owned. Their edges are picked up on a later SCAN if they persist.
- Latency on an idle controller: evt_valid rises DEBOUNCE_CYC+4 clock edges after the first edge that samples the new key_in level. key_state updates on the same edge.
- FIFO handshake:
  - Pop on evt_valid&&evt_ready.
  - evt_key and evt_press are registered from the FIFO head and hold while evt_valid&&!evt_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Pop when empty has no effect.
- Reset mid-debounce discards the in-progress edge and empties the FIFO. Keys held through reset are re-detected as press events after release of reset.

Optional Feature:
- KEY_SCAN_RELEASE_EN
  - Defined: both press and release edges are queued (behaviour above).
  - Undefined: release commits toggle stable[idx] and update key_state without pushing and never stall. Only press events enter the FIFO, and evt_press is constant 1.

Decomposition:
- Shared package key_pkg:
  - FSM state enum (SCAN/DEBOUNCE/COMMIT)
  - event struct {key index, press bit}
  - default DEBOUNCE_CYC constant for 100 MHz
- One natural sub-module: key_evt_fifo, a synchronous FIFO with FIFO_DEPTH, full/empty, registered head, push and pop in the same cycle.

Test Plan (DEBOUNCE_CYC=16, NUM_KEYS=4, FIFO_DEPTH=4, KEY_SCAN_RELEASE_EN defined):
- Hold rst=0 for 7 cycles, then release → evt_valid=0, key_state=4'b0000, busy=0.
- Key 1 goes to 1 and holds, evt_ready=1 → evt_valid pulses 20 edges later with evt_key=1, evt_press=1; key_state=4'b0010.
- Key 2 bounces high 1 cycle, low 1.5 cycles, repeatedly for 200 ns, then holds high → no event during the bounce; exactly one press event for key 2 after the level settles.
- Keys 0 and 3 rise on the same cycle with ptr=0 → events in order key 0, then key 3. The second event lands DEBOUNCE_CYC+2 cycles after the first.
- evt_ready=0 while 5 edges occur → FIFO holds 4 events and the 5th commit stalls with busy=1. Raising evt_ready drains all 5 events in order with none lost.
- Assert rst during DEBOUNCE of key 1 → no event after release of rst. The key still held triggers a fresh press event DEBOUNCE_CYC+4 edges later.
